// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scanline builder.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE, SCAN_ADDR, SCAN_DATA, FETCH_ADDR, FETCH_DATA, DRAW, DONE
  } state_t;

  localparam logic [7:0] TERMINATOR_Y = 8'hD0;
  localparam int         MAX_PER_LINE = 8;
  localparam int         NUM_SPRITES  = 64;
  localparam logic [7:0] SAT_XOFF     = 8'h80;

  typedef struct packed {
    logic [5:0] idx;
    logic [3:0] row;
  } sel_t;

endpackage

// File: rtl/sprite_row_merge.sv
// Composites one 8-pixel sprite row into the scanline plane buffers.
module sprite_row_merge
  import sprite_pkg::*;
(
  input  logic [7:0]         x,
  input  logic [3:0][7:0]    planes,
  input  logic [3:0][255:0]  buf_in,
  input  logic [255:0]       en_in,
  output logic [3:0][255:0]  buf_out,
  output logic [255:0]       en_out,
  output logic               collide
);

  logic [8:0] col;
  logic [7:0] pos;
  logic [3:0] colour;

  always_comb begin
    buf_out = buf_in;
    en_out  = en_in;
    collide = 1'b0;
    col     = '0;
    pos     = '0;
    colour  = '0;
    for (int i = 0; i < 8; i++) begin
      col    = {1'b0, x} + 9'(i);
      colour = {planes[3][3'(7 - i)], planes[2][3'(7 - i)],
                planes[1][3'(7 - i)], planes[0][3'(7 - i)]};
      // Pixels past column 255 are clipped, never wrapped; earlier sprites keep the column.
      if (!col[8] && colour != 4'd0) begin
        pos = ~col[7:0];
        if (en_out[pos]) begin
          collide = 1'b1;
        end else begin
          en_out[pos] = 1'b1;
          for (int p = 0; p < 4; p++) buf_out[p][pos] = colour[p];
        end
      end
    end
  end

endmodule

// File: rtl/sprite_line_builder.sv
// Scans the SAT for sprites on one scanline, fetches their patterns and
// composites them into 256-column plane buffers for the pixel shifter.
module sprite_line_builder
  import sprite_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   line,
  input  logic [5:0]   satBase,
  input  logic         patBase,
  input  logic         tall,
  input  logic         clearFlags,
  output logic [13:0]  vramAddr,
  output logic         vramRe,
  input  logic [7:0]   vramData,
  output logic [255:0] spriteOut0,
  output logic [255:0] spriteOut1,
  output logic [255:0] spriteOut2,
  output logic [255:0] spriteOut3,
  output logic [255:0] spriteEn,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         collision
);

  state_t              state, state_nx;
  logic [5:0]          n;
  logic [3:0]          count;
  logic [2:0]          k;
  logic [2:0]          step;
  logic [7:0]          line_q;
  logic                tall_q;
  sel_t                sel [MAX_PER_LINE];
  logic [7:0]          x_q, p_q;
  logic [3:0][7:0]     planes_q;
  logic [3:0][255:0]   bufs;
  logic [255:0]        en_q;

  logic [3:0][255:0]   bufs_nx;
  logic [255:0]        en_nx;
  logic                collide;

  logic [7:0]          y_d;
  logic                in_range, is_term, keep, ovf_set, scan_end;
  sel_t                cur;
  logic [13:0]         sat_x, pat_addr;

  sprite_row_merge u_merge (
    .x       (x_q),
    .planes  (planes_q),
    .buf_in  (bufs),
    .en_in   (en_q),
    .buf_out (bufs_nx),
    .en_out  (en_nx),
    .collide (collide)
  );

  // A sprite at Y first appears on line Y+1, so d is the row within it.
  assign y_d      = line_q - (vramData + 8'd1);
  assign in_range = tall_q ? (y_d < 8'd16) : (y_d < 8'd8);
  assign is_term  = (vramData == TERMINATOR_Y);
  assign keep     = (state == SCAN_DATA) && !is_term && in_range && (count < 4'(MAX_PER_LINE));
  assign ovf_set  = (state == SCAN_DATA) && !is_term && in_range && (count == 4'(MAX_PER_LINE));
  assign scan_end = is_term || ovf_set || (n == 6'(NUM_SPRITES - 1));

  assign cur      = sel[k];
  assign sat_x    = {satBase, SAT_XOFF} + {7'b0, cur.idx, 1'b0};
  assign pat_addr = {patBase, 13'b0} + {1'b0, p_q, 5'b0} + {8'b0, cur.row, 2'b0}
                  + {11'b0, 3'(step - 3'd2)};

  always_comb begin
    state_nx = state;
    vramRe   = 1'b0;
    vramAddr = '0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:       if (start) state_nx = SCAN_ADDR;
      SCAN_ADDR: begin
        vramRe   = 1'b1;
        vramAddr = {satBase, 8'h00} + {8'b0, n};
        state_nx = SCAN_DATA;
      end
      SCAN_DATA: begin
        if (scan_end) state_nx = (count != 4'd0 || keep) ? FETCH_ADDR : DONE;
        else          state_nx = SCAN_ADDR;
      end
      FETCH_ADDR: begin
        vramRe   = 1'b1;
        vramAddr = (step == 3'd0) ? sat_x : (step == 3'd1) ? sat_x + 14'd1 : pat_addr;
        state_nx = FETCH_DATA;
      end
      FETCH_DATA: state_nx = (step == 3'd5) ? DRAW : FETCH_ADDR;
      DRAW:       state_nx = ({1'b0, k} == count - 4'd1) ? DONE : FETCH_ADDR;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      count     <= '0;
      k         <= '0;
      step      <= '0;
      line_q    <= '0;
      tall_q    <= 1'b0;
      x_q       <= '0;
      p_q       <= '0;
      planes_q  <= '0;
      bufs      <= '0;
      en_q      <= '0;
      overflow  <= 1'b0;
      collision <= 1'b0;
      for (int i = 0; i < MAX_PER_LINE; i++) sel[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          bufs   <= '0;
          en_q   <= '0;
          n      <= '0;
          count  <= '0;
          k      <= '0;
          step   <= '0;
          line_q <= line;
          tall_q <= tall;
        end
        SCAN_DATA: begin
          if (keep) begin
            sel[count[2:0]] <= '{idx: n, row: y_d[3:0]};
            count           <= count + 4'd1;
          end
          if (!scan_end) n <= n + 6'd1;
        end
        FETCH_DATA: begin
          case (step)
            3'd0:    x_q <= vramData;
            3'd1:    p_q <= tall_q ? {vramData[7:1], 1'b0} : vramData;
            default: planes_q[2'(step - 3'd2)] <= vramData;
          endcase
          step <= (step == 3'd5) ? 3'd0 : step + 3'd1;
        end
        DRAW: begin
          bufs <= bufs_nx;
          en_q <= en_nx;
          k    <= k + 3'd1;
        end
        default: ;
      endcase
      // Setting a flag takes precedence over a simultaneous clear.
      if (ovf_set)                        overflow  <= 1'b1;
      else if (clearFlags)                overflow  <= 1'b0;
      if (state == DRAW && collide)       collision <= 1'b1;
      else if (clearFlags)                collision <= 1'b0;
    end
  end

  assign spriteOut0 = bufs[0];
  assign spriteOut1 = bufs[1];
  assign spriteOut2 = bufs[2];
  assign spriteOut3 = bufs[3];
  assign spriteEn   = en_q;

endmodule

// File: tb/tb_sprite_line_builder.sv
// Directed self-checking bench for sprite_line_builder with a VRAM model.
module tb_sprite_line_builder;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, patBase, tall, clearFlags, vramRe, busy, done, overflow, collision;
  logic [7:0]   line, vramData;
  logic [5:0]   satBase;
  logic [13:0]  vramAddr;
  logic [255:0] spriteOut0, spriteOut1, spriteOut2, spriteOut3, spriteEn;

  logic [7:0]   vram [0:16383];
  logic [13:0]  alog [$];
  int           errors = 0;
  int           checks = 0;

  sprite_line_builder dut (
    .clk(clk), .rst(rst), .start(start), .line(line), .satBase(satBase),
    .patBase(patBase), .tall(tall), .clearFlags(clearFlags),
    .vramAddr(vramAddr), .vramRe(vramRe), .vramData(vramData),
    .spriteOut0(spriteOut0), .spriteOut1(spriteOut1), .spriteOut2(spriteOut2),
    .spriteOut3(spriteOut3), .spriteEn(spriteEn), .busy(busy), .done(done),
    .overflow(overflow), .collision(collision)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (vramRe) vramData <= vram[vramAddr];
  always @(negedge clk) if (vramRe) alog.push_back(vramAddr);

  function automatic logic [255:0] cols(input int x, input int cnt);
    logic [255:0] m = '0;
    for (int c = x; c < x + cnt; c++) if (c < 256) m[255 - c] = 1'b1;
    return m;
  endfunction

  task automatic clear_vram();
    for (int a = 0; a < 16384; a++) vram[a] = 8'h00;
  endtask

  task automatic put_sprite(input int idx, input logic [7:0] y, input logic [7:0] x,
                            input logic [7:0] p);
    vram[14'h1F00 + idx]       = y;
    vram[14'h1F80 + 2*idx]     = x;
    vram[14'h1F80 + 2*idx + 1] = p;
  endtask

  task automatic run_build(input logic [7:0] ln, input logic tl, output int lat);
    @(negedge clk);
    alog.delete();
    line = ln; tall = tl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, vramRe, overflow, collision} !== 5'b0 || vramAddr !== 14'd0) begin
      errors++; $display("FAIL reset_ctrl: got busy/done/re/ovf/col=%b addr=%h, want 0", {busy, done, vramRe, overflow, collision}, vramAddr);
    end
    checks++;
    if ((spriteEn | spriteOut0 | spriteOut1 | spriteOut2 | spriteOut3) !== 256'd0) begin
      errors++; $display("FAIL reset_bufs: buffers nonzero, want 0");
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vramRe !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b re=%b want 0 0", busy, vramRe);
    end
  endtask

  task automatic test_empty();
    int lat;
    clear_vram();
    put_sprite(0, 8'hD0, 8'd0, 8'd0);
    @(negedge clk);
    line = 8'd10; tall = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || vramRe !== 1'b1 || vramAddr !== 14'h1F00) begin
      errors++; $display("FAIL empty_first_read: busy=%b re=%b addr=%h want 1 1 1f00", busy, vramRe, vramAddr);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat + 1 != 4) begin
      errors++; $display("FAIL empty_latency: done in cycle %0d, want 4", lat + 1);
    end
    checks++;
    if ((spriteEn | spriteOut0) !== 256'd0 || overflow !== 1'b0 || collision !== 1'b0) begin
      errors++; $display("FAIL empty_result: en=%h ovf=%b col=%b want all 0", spriteEn, overflow, collision);
    end
  endtask

  task automatic test_single();
    int lat;
    clear_vram();
    put_sprite(0, 8'd9, 8'd16, 8'd2);
    put_sprite(1, 8'hD0, 8'd0, 8'd0);
    vram[14'h2040] = 8'hFF;
    run_build(8'd10, 1'b0, lat);
    checks++;
    if (lat >= 1000) begin
      errors++; $display("FAIL single_timeout: no done after %0d cycles", lat);
    end
    checks++;
    if (spriteEn !== cols(16, 8) || spriteOut0 !== cols(16, 8)) begin
      errors++; $display("FAIL single_en_out0: en=%h out0=%h want %h", spriteEn, spriteOut0, cols(16, 8));
    end
    checks++;
    if ((spriteOut1 | spriteOut2 | spriteOut3) !== 256'd0) begin
      errors++; $display("FAIL single_out123: nonzero, want 0");
    end
    checks++;
    if (alog.size() < 8 || alog[2] !== 14'h1F80 || alog[3] !== 14'h1F81 || alog[4] !== 14'h2040 || alog[7] !== 14'h2043) begin
      errors++; $display("FAIL single_addrs: got %0d reads x=%h p=%h pl0=%h, want 1f80 1f81 2040", alog.size(), alog[2], alog[3], alog[4]);
    end
  endtask

  task automatic test_right_edge();
    int lat;
    clear_vram();
    put_sprite(0, 8'd9, 8'd252, 8'd0);
    put_sprite(1, 8'hD0, 8'd0, 8'd0);
    for (int p = 0; p < 4; p++) vram[14'h2000 + p] = 8'hFF;
    run_build(8'd10, 1'b0, lat);
    checks++;
    if (spriteEn !== 256'hF || spriteOut0 !== 256'hF || spriteOut3 !== 256'hF) begin
      errors++; $display("FAIL edge_clip: en=%h out0=%h out3=%h want f", spriteEn, spriteOut0, spriteOut3);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [255:0] exp_en;
    clear_vram();
    exp_en = '0;
    for (int i = 0; i < 9; i++) put_sprite(i, 8'd9, 8'(i * 16), 8'd1);
    for (int i = 0; i < 8; i++) exp_en[255 - i * 16] = 1'b1;
    vram[14'h2020] = 8'h80;
    run_build(8'd10, 1'b0, lat);
    checks++;
    if (spriteEn !== exp_en || spriteOut0 !== exp_en) begin
      errors++; $display("FAIL ovf_drawn: en=%h want %h", spriteEn, exp_en);
    end
    checks++;
    if (overflow !== 1'b1 || collision !== 1'b0) begin
      errors++; $display("FAIL ovf_flag: ovf=%b col=%b want 1 0", overflow, collision);
    end
    @(negedge clk);
    clearFlags = 1'b1;
    @(negedge clk);
    clearFlags = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: ovf=%b want 0", overflow);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (spriteEn !== exp_en) begin
      errors++; $display("FAIL ovf_hold: en=%h want %h", spriteEn, exp_en);
    end
  endtask

  task automatic test_collision();
    int lat;
    clear_vram();
    put_sprite(0, 8'd9, 8'd40, 8'd1);
    put_sprite(1, 8'd9, 8'd40, 8'd3);
    put_sprite(2, 8'hD0, 8'd0, 8'd0);
    vram[14'h2020] = 8'hFF;
    vram[14'h2061] = 8'hFF;
    run_build(8'd10, 1'b0, lat);
    checks++;
    if (spriteOut0 !== cols(40, 8) || spriteOut1 !== 256'd0 || spriteEn !== cols(40, 8)) begin
      errors++; $display("FAIL col_priority: out0=%h out1=%h want %h 0", spriteOut0, spriteOut1, cols(40, 8));
    end
    checks++;
    if (collision !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL col_flag: col=%b ovf=%b want 1 0", collision, overflow);
    end
  endtask

  task automatic test_tall_abort();
    int cyc;
    clear_vram();
    put_sprite(0, 8'd9, 8'd0, 8'd5);
    put_sprite(1, 8'd9, 8'd100, 8'd5);
    put_sprite(2, 8'hD0, 8'd0, 8'd0);
    vram[14'h20A8] = 8'hFF;
    @(negedge clk);
    alog.delete();
    line = 8'd20; tall = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (alog.size() < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (alog.size() < 12) begin
      errors++; $display("FAIL tall_timeout: %0d reads seen, want 12", alog.size());
    end
    checks++;
    if (alog[4] !== 14'h1F81 || alog[5] !== 14'h20A8 || alog[8] !== 14'h20AB) begin
      errors++; $display("FAIL tall_addrs: p=%h pl0=%h pl3=%h want 1f81 20a8 20ab", alog[4], alog[5], alog[8]);
    end
    checks++;
    if (spriteEn !== cols(0, 8) || busy !== 1'b1) begin
      errors++; $display("FAIL tall_partial: en=%h busy=%b want %h 1", spriteEn, busy, cols(0, 8));
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, vramRe, overflow, collision} !== 5'b0 || vramAddr !== 14'd0) begin
      errors++; $display("FAIL abort_ctrl: busy/done/re/ovf/col=%b addr=%h want 0", {busy, done, vramRe, overflow, collision}, vramAddr);
    end
    checks++;
    if ((spriteEn | spriteOut0 | spriteOut1 | spriteOut2 | spriteOut3) !== 256'd0) begin
      errors++; $display("FAIL abort_bufs: en=%h want 0", spriteEn);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; line = '0; satBase = 6'h1F; patBase = 1'b1;
    tall = 1'b0; clearFlags = 1'b0;
    test_reset();
    test_empty();
    test_single();
    test_right_edge();
    test_overflow();
    test_collision();
    test_tall_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_line_builder.md
# sprite_line_builder

Builds one scanline of sprite pixels ahead of the pixel shifter stage. On `start`, it scans the 64-entry sprite attribute table (SAT) in VRAM for sprites that intersect `line`, keeping at most 8. It fetches each kept sprite's four pattern bitplane bytes and composites them into the 256-column plane buffers `spriteOut0..3` and `spriteEn`, which the shifter latches on its `we`. It also raises the VDP sprite overflow and collision flags.

## Interface
- No parameters. Constants are in `sprite_pkg`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a build. Ignored unless idle.
- `line` in 8: scanline to build.
- `satBase` in 6: VRAM address bits 13:8 of the SAT.
- `patBase` in 1: VRAM address bit 13 of the sprite pattern table.
- `tall` in 1: 0 selects 8x8 sprites, 1 selects 8x16 sprites.
- `clearFlags` in 1: clears `overflow` and `collision`.
- `vramAddr` out 14: VRAM read address.
- `vramRe` out 1: read strobe. Data is valid on `vramData` exactly one cycle after the strobe.
- `vramData` in 8: VRAM read data.
- `spriteOut0..3` out 256 each: colour bitplanes 0–3. Column x is at bit 255−x.
- `spriteEn` out 256: column holds an opaque sprite pixel.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse when the buffers are final.
- `overflow` out 1: sticky; a 9th sprite was found on a line.
- `collision` out 1: sticky; two opaque sprite pixels landed in one column.

## Operation
**Reset values:** all outputs are 0, state is IDLE, the selection list is empty.

**State machine:**
- IDLE: on `start`, clear all five plane buffers, set n=0, count=0, latch `line`/`tall` → SCAN_ADDR.
- SCAN_ADDR: `vramAddr={satBase,8'h00}+n`, `vramRe`=1 → SCAN_DATA.
- SCAN_DATA: Y=`vramData`.
  - If Y==8'hD0: end scan.
  - Otherwise compute d=(line−(Y+1)) mod 256. The sprite is in range if d<8, or d<16 when tall.
  - In range with count<8: store {n, row=d[3:0]} and increment count.
  - In range with count==8: set `overflow` and end scan.
  - After the range check, if n==63 end scan; otherwise n++ → SCAN_ADDR.
  - End scan: go to FETCH_ADDR if count>0, else DONE.
- FETCH_ADDR / FETCH_DATA: for entry k (k=0..count−1), issue 6 reads, each taking 2 cycles (address, then data), in this order:
  - X at `{satBase,8'h80}+2n`.
  - pattern P at `{satBase,8'h81}+2n`. When tall, bit 0 of P is cleared.
  - planes p=0..3 at `{patBase,13'b0}+P*32+row*4+p`. 14-bit sum; carries past bit 13 are dropped.
  - After the 4th plane byte → DRAW.
- DRAW (1 cycle): for pixel i=0..7:
  - Column c=X+i. Skip the pixel if c>255.
  - The colour is bit 7−i of planes 3..0. The pixel is opaque if the colour is nonzero.
  - If opaque and `spriteEn[255−c]` is already set: set `collision` and leave the column unchanged. The lower table index has priority.
  - Else if opaque: write the four plane bits and set `spriteEn[255−c]`.
  - Then go to the next k, or DONE after the last entry.
- DONE: `done`=1 for one cycle → IDLE.

**Other rules:**
- The buffers hold their value from `done` until the next accepted `start`.
- `clearFlags` is ignored in any cycle where the block sets a flag; setting wins.
- Asserting `rst` mid-build aborts the build and restores the reset values.

## Timing
- `start` to first `vramRe`: 1 cycle.
- Scan costs 2 cycles per entry examined; the worst case is 128 cycles.
- Each kept sprite costs 13 cycles.
- Worst-case build is 1+128+8×13+1 = 234 cycles, which fits within one 342-cycle line.
- Empty SAT (entry 0 is D0): `done` arrives 4 cycles after `start`.
- `vramRe` is high only in SCAN_ADDR and FETCH_ADDR.

## Structure
- `sprite_pkg`:
  - state enum {IDLE, SCAN_ADDR, SCAN_DATA, FETCH_ADDR, FETCH_DATA, DRAW, DONE}
  - `TERMINATOR_Y=8'hD0`, `MAX_PER_LINE=8`, `NUM_SPRITES=64`, `SAT_XOFF=8'h80`
- Sub-module `sprite_row_merge`: combinational. Takes X, four plane bytes and the current buffers; returns the next buffers and a collision bit. It is used in DRAW.

## Test plan
- SAT entry 0 has Y=8'hD0, `start` with line=10: `done` at cycle 4; all buffers 0; no flags set.
- Sprite 0 at Y=9, X=16, P=2, plane0 byte=8'hFF, other planes 0, line=10 → `spriteEn` and `spriteOut0` bits 239..232 set; `vramAddr` for plane 0 = 0x2040 with `patBase`=1.
- Sprite at X=252, all planes 8'hFF → only columns 252–255 are set (bits 3..0); no wrap into column 0.
- Nine sprites with Y=9 on line 10 → the first 8 are drawn, `overflow`=1; `clearFlags` then returns it to 0.
- Sprites 0 and 1 at the same X, both opaque → sprite 0's colour wins, `collision`=1.
- `tall`=1, Y=9, line=20, P=5 → P is used as 4, row=10; plane address = base+4×32+10×4+p. Assert `rst` mid-fetch → all outputs return to 0 and `busy`=0 on the next cycle.
